mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between the instruction-fetch port and the data-access (MEM-stage) port of the pipelined core.
- Serialises requests, holds the memory handshake and returns per-port ready/data pulses.
- Drives a pipeline stall while any request is outstanding.
- Includes a watchdog that terminates a transaction with an error if the memory never acknowledges.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between instruction fetch and data access
//
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, the data port wins when both ports request.
//   defined   : alternating priority through a one-bit last-grant register (resets to data).
//
// Parameters:
//   ADDR_W         address width of both ports and the memory
//   TIMEOUT_CYCLES WAIT cycles before the watchdog aborts a transaction; 0 disables it
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   i_req_i, i_addr_i              instruction read request (held until i_ready_o)
//   i_rdata_o, i_ready_o           instruction data and one-cycle completion pulse
//   d_req_i, d_we_i, d_width_i,    data request (held until d_ready_o); width 00 byte,
//   d_addr_i, d_wdata_i            01 half, 10 word
//   d_rdata_o, d_ready_o           data read data and one-cycle completion pulse
//   err_o                          set alongside a ready pulse when the transaction timed out
//   stall_o                        pipeline stall while a port has an unfinished request
//   mem_req_o, mem_we_o,           registered memory request, held stable until mem_ack_i
//   mem_width_o, mem_addr_o,
//   mem_wdata_o
//   mem_rdata_i, mem_ack_i         memory read data and one-cycle completion

module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [31:0]       i_rdata_o,
    output logic              i_ready_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [1:0]        d_width_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic [31:0]       d_rdata_o,
    output logic              d_ready_o,

    output logic              err_o,
    output logic              stall_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [1:0]        mem_width_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Wide enough to hold TIMEOUT_CYCLES itself, and at least one bit when disabled.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

    state_t           state;
    logic             grant_d;    // 1: the data port owns the current transaction
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             timeout_hit;
    logic             pick_d;     // arbitration result used when leaving IDLE

    assign cnt_next    = wait_cnt + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_next == CNT_W'(TIMEOUT_CYCLES));

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;                 // 1: the data port received the most recent grant

    always_comb begin
        pick_d = d_req_i;
        if (d_req_i && i_req_i) begin
            pick_d = ~last_d;
        end
    end
`else
    assign pick_d = d_req_i;
`endif

    // Only requests not yet answered hold the pipeline; the ready cycle itself releases it.
    assign stall_o = (i_req_i & ~i_ready_o) | (d_req_i & ~d_ready_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            grant_d     <= 1'b0;
            wait_cnt    <= '0;
            i_rdata_o   <= 32'h0;
            i_ready_o   <= 1'b0;
            d_rdata_o   <= 32'h0;
            d_ready_o   <= 1'b0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_width_o <= 2'b00;
            mem_addr_o  <= '0;
            mem_wdata_o <= 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d      <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    i_ready_o <= 1'b0;
                    d_ready_o <= 1'b0;
                    err_o     <= 1'b0;
                    i_rdata_o <= 32'h0;
                    d_rdata_o <= 32'h0;
                    wait_cnt  <= '0;
                    if (d_req_i || i_req_i) begin
                        grant_d   <= pick_d;
                        mem_req_o <= 1'b1;
                        state     <= S_WAIT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d    <= pick_d;
`endif
                        if (pick_d) begin
                            mem_we_o    <= d_we_i;
                            mem_width_o <= d_width_i;
                            mem_addr_o  <= d_addr_i;
                            mem_wdata_o <= d_wdata_i;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_width_o <= 2'b10;
                            mem_addr_o  <= i_addr_i;
                            mem_wdata_o <= 32'h0;
                        end
                    end
                end

                S_WAIT: begin
                    // An ack in the expiry cycle wins over the watchdog.
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= S_RESP;
                        if (grant_d) begin
                            d_ready_o <= 1'b1;
                            d_rdata_o <= mem_we_o ? 32'h0 : mem_rdata_i;
                        end else begin
                            i_ready_o <= 1'b1;
                            i_rdata_o <= mem_rdata_i;
                        end
                    end else if (timeout_hit) begin
                        mem_req_o <= 1'b0;
                        state     <= S_RESP;
                        err_o     <= 1'b1;
                        if (grant_d) begin
                            d_ready_o <= 1'b1;
                        end else begin
                            i_ready_o <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= cnt_next;
                    end
                end

                S_RESP: begin
                    // Always pass through IDLE so a still-held request is not regranted here.
                    i_ready_o <= 1'b0;
                    d_ready_o <= 1'b0;
                    err_o     <= 1'b0;
                    i_rdata_o <= 32'h0;
                    d_rdata_o <= 32'h0;
                    wait_cnt  <= '0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          i_req_i;
    logic [AW-1:0] i_addr_i;
    logic [31:0]   i_rdata_o;
    logic          i_ready_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [1:0]    d_width_i;
    logic [AW-1:0] d_addr_i;
    logic [31:0]   d_wdata_i;
    logic [31:0]   d_rdata_o;
    logic          d_ready_o;
    logic          err_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [1:0]    mem_width_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_ack_i;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_ready_o(i_ready_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_width_i(d_width_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
        .err_o(err_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_width_o(mem_width_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    typedef struct {
        logic        port_d;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic        we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    resp_t resp_q[$];
    mreq_t mreq_q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    n_ready   = 0;
    int    exp_ready = 0;
    logic  tb_last_d = 1'b1;   // reference model of the last-grant register
    logic  prev_req  = 1'b0;
    mreq_t cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_resp(input logic pd, input logic [31:0] rd, input logic e);
        resp_t r;
        r.port_d = pd;
        r.rdata  = rd;
        r.err    = e;
        resp_q.push_back(r);
        exp_ready++;
    endtask

    task automatic exp_mem(input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] wd);
        mreq_t m;
        m.we    = we;
        m.width = w;
        m.addr  = a;
        m.wdata = wd;
        mreq_q.push_back(m);
    endtask

    // Response scoreboard: every ready pulse pops one expected response.
    always @(negedge clk_i) begin
        if (i_ready_o || d_ready_o) begin
            resp_t r;
            n_ready++;
            check("resp_expected", resp_q.size() != 0, 1'b1);
            if (resp_q.size() != 0) begin
                r = resp_q.pop_front();
                check("resp_d_ready", d_ready_o, r.port_d);
                check("resp_i_ready", i_ready_o, !r.port_d);
                check("resp_rdata", r.port_d ? d_rdata_o : i_rdata_o, r.rdata);
                check("resp_other_rdata", r.port_d ? i_rdata_o : d_rdata_o, 32'h0);
                check("resp_err", err_o, r.err);
            end
        end
    end

    // Memory-request scoreboard: each rising mem_req_o pops one expected request,
    // and the fields must stay put while the request is held.
    always @(negedge clk_i) begin
        if (mem_req_o && !prev_req) begin
            check("mreq_expected", mreq_q.size() != 0, 1'b1);
            if (mreq_q.size() != 0) begin
                cur = mreq_q.pop_front();
                check("mreq_we", mem_we_o, cur.we);
                check("mreq_width", mem_width_o, cur.width);
                check("mreq_addr", mem_addr_o, cur.addr);
                check("mreq_wdata", mem_wdata_o, cur.wdata);
            end
        end else if (mem_req_o) begin
            check("mreq_stable", {mem_we_o, mem_width_o, mem_addr_o[28:0]},
                  {cur.we, cur.width, cur.addr[28:0]});
        end
        prev_req = mem_req_o;
    end

    // Memory responder: waits for mem_req_o, acks on WAIT cycle ack_at (0 = never),
    // returns at the negedge following the request's end, which is the ready cycle.
    task automatic serve(input int ack_at, input logic [31:0] rd, output int n);
        int guard;
        n = 0;
        guard = 0;
        while (!mem_req_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        check("serve_req_seen", mem_req_o, 1'b1);
        while (mem_req_o && n < 20) begin
            n++;
            if (n == ack_at) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rd;
            end
            @(negedge clk_i);
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hFFFF_0000;
        end
    endtask

    task automatic pair(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
        logic        first_d;
        logic [31:0] ird;
        int          n;
        ird = ia ^ 32'h5A5A_0000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first_d = !tb_last_d;
`else
        first_d = 1'b1;
`endif
        i_req_i = 1'b1; i_addr_i = ia;
        d_req_i = 1'b1; d_we_i = 1'b1; d_width_i = 2'b00; d_addr_i = da; d_wdata_i = wd;
        if (first_d) begin
            exp_mem(1'b1, 2'b00, da, wd); exp_mem(1'b0, 2'b10, ia, 32'h0);
            exp_resp(1'b1, 32'h0, 1'b0);  exp_resp(1'b0, ird, 1'b0);
        end else begin
            exp_mem(1'b0, 2'b10, ia, 32'h0); exp_mem(1'b1, 2'b00, da, wd);
            exp_resp(1'b0, ird, 1'b0);       exp_resp(1'b1, 32'h0, 1'b0);
        end
        tb_last_d = !first_d;
        // Memory returns nonzero data on the write ack; the write must still report 0.
        serve(1, first_d ? 32'h1234_5678 : ird, n);
        check("pair_first_cycles", n, 1);
        check("pair_first_ready", first_d ? d_ready_o : i_ready_o, 1'b1);
        if (first_d) d_req_i = 1'b0; else i_req_i = 1'b0;
        @(negedge clk_i);
        check("pair_gap_idle", mem_req_o, 1'b0);
        @(negedge clk_i);
        check("pair_second_grant", mem_req_o, 1'b1);
        serve(2, first_d ? ird : 32'h1234_5678, n);
        check("pair_second_cycles", n, 2);
        i_req_i = 1'b0; d_req_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int r0;
        rst_i = 1'b1;
        i_req_i = 1'b0; i_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_width_i = 2'b00; d_addr_i = '0; d_wdata_i = 32'h0;
        mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_we", mem_we_o, 1'b0);
        check("rst_mem_width", mem_width_o, 2'b00);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        check("rst_ready", {i_ready_o, d_ready_o, err_o}, 3'b000);
        check("rst_i_rdata", i_rdata_o, 32'h0);
        check("rst_d_rdata", d_rdata_o, 32'h0);
        check("rst_stall", stall_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Isolated instruction fetch, ack on the second WAIT cycle.
        i_req_i = 1'b1; i_addr_i = 32'h100;
        exp_mem(1'b0, 2'b10, 32'h100, 32'h0);
        exp_resp(1'b0, 32'hDEAD_BEEF, 1'b0);
        tb_last_d = 1'b0;
        @(negedge clk_i);
        check("fetch_stall_busy", stall_o, 1'b1);
        serve(2, 32'hDEAD_BEEF, n);
        check("fetch_req_cycles", n, 2);
        check("fetch_ready", i_ready_o, 1'b1);
        check("fetch_stall_drop", stall_o, 1'b0);
        i_req_i = 1'b0;
        @(negedge clk_i);

        // Simultaneous instruction and data requests, twice.
        pair(32'h300, 32'h200, 32'h55);
        pair(32'h304, 32'h204, 32'hA6);

        // Watchdog expiry: no ack at all.
        d_req_i = 1'b1; d_we_i = 1'b0; d_width_i = 2'b01; d_addr_i = 32'h400; d_wdata_i = 32'h77;
        exp_mem(1'b0, 2'b01, 32'h400, 32'h77);
        exp_resp(1'b1, 32'h0, 1'b1);
        tb_last_d = 1'b1;
        serve(0, 32'h0, n);
        check("timeout_req_cycles", n, TO);
        check("timeout_err", err_o, 1'b1);
        d_req_i = 1'b0;
        @(negedge clk_i);

        // The following transaction must report no error.
        d_req_i = 1'b1; d_width_i = 2'b10; d_addr_i = 32'h404;
        exp_mem(1'b0, 2'b10, 32'h404, 32'h77);
        exp_resp(1'b1, 32'hCAFE_F00D, 1'b0);
        serve(3, 32'hCAFE_F00D, n);
        check("after_timeout_cycles", n, 3);
        check("after_timeout_err", err_o, 1'b0);
        d_req_i = 1'b0;
        @(negedge clk_i);

        // Ack while idle is ignored.
        r0 = n_ready;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("idle_ack_no_ready", n_ready, r0);
        check("idle_ack_no_req", mem_req_o, 1'b0);

        // Ack in the very cycle the watchdog would expire.
        d_req_i = 1'b1; d_addr_i = 32'h408;
        exp_mem(1'b0, 2'b10, 32'h408, 32'h77);
        exp_resp(1'b1, 32'h0BAD_C0DE, 1'b0);
        serve(TO, 32'h0BAD_C0DE, n);
        check("collision_cycles", n, TO);
        check("collision_err", err_o, 1'b0);
        d_req_i = 1'b0;
        @(negedge clk_i);

        // Reset in the middle of WAIT with the request held.
        i_req_i = 1'b1; i_addr_i = 32'h500;
        exp_mem(1'b0, 2'b10, 32'h500, 32'h0);
        tb_last_d = 1'b0;
        n = 0;
        while (!mem_req_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        check("rst_wait_req_before", mem_req_o, 1'b1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_wait_req_drop", mem_req_o, 1'b0);
        check("rst_wait_no_ready", i_ready_o, 1'b0);
        check("rst_wait_stall", stall_o, 1'b1);
        rst_i = 1'b0;
        tb_last_d = 1'b1;
        exp_mem(1'b0, 2'b10, 32'h500, 32'h0);
        exp_resp(1'b0, 32'h1111_2222, 1'b0);
        tb_last_d = 1'b0;
        serve(1, 32'h1111_2222, n);
        check("rst_regrant_cycles", n, 1);
        i_req_i = 1'b0;
        @(negedge clk_i);

        // Back-to-back data reads with the request held across the ready cycle.
        d_req_i = 1'b1; d_we_i = 1'b0; d_width_i = 2'b10; d_addr_i = 32'h600; d_wdata_i = 32'h0;
        exp_mem(1'b0, 2'b10, 32'h600, 32'h0);
        exp_mem(1'b0, 2'b10, 32'h600, 32'h0);
        exp_resp(1'b1, 32'hAAAA_0001, 1'b0);
        exp_resp(1'b1, 32'hBBBB_0002, 1'b0);
        tb_last_d = 1'b1;
        serve(1, 32'hAAAA_0001, n);
        check("b2b_first_ready", d_ready_o, 1'b1);
        @(negedge clk_i);
        check("b2b_bubble", mem_req_o, 1'b0);
        @(negedge clk_i);
        check("b2b_regrant", mem_req_o, 1'b1);
        serve(1, 32'hBBBB_0002, n);
        check("b2b_second_cycles", n, 1);
        d_req_i = 1'b0;

        repeat (3) @(negedge clk_i);
        check("resp_q_drained", resp_q.size(), 0);
        check("mreq_q_drained", mreq_q.size(), 0);
        check("ready_pulse_count", n_ready, exp_ready);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
